// File: rtl/seg_display_mux_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Glyph table, scan-state enum and the leading-zero blanking helper.
package seg_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Digit i blanks while it and all higher digits are 0 with no dp lit.
  function automatic logic [3:0] lz_blank(
    input logic [15:0] d,
    input logic [3:0]  dp
  );
    logic       run;
    logic [3:0] m;
    run = 1'b1;
    m   = '0;
    for (int i = 3; i >= 0; i--) begin
      run  = run & (d[i*4 +: 4] == 4'd0) & ~dp[i];
      m[i] = run;
    end
    return m & 4'b1110;
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Digit/mask load bus and display pin bundle for seg_display_mux.
interface seg_display_mux_if;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [7:0]  Seg;
  logic        decimal;
  logic [3:0]  an;

  modport master (
    output load, digits, dp_mask, blank_mask,
    input  Seg, decimal, an
  );

  modport slave (
    input  load, digits, dp_mask, blank_mask,
    output Seg, decimal, an
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low gfedcba hex glyph.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_glyph
);
  assign o_glyph = GLYPH[i_code];
endmodule

// File: rtl/seg_display_mux.sv
// Four-digit time-multiplexed 7-seg driver with anti-ghost guard slots.
// Optional SEG_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 250,
  parameter int GUARD_CYC  = 64
) (
  input  logic               clk,
  input  logic               reset,
  seg_display_mux_if.slave   bus
);
  localparam int SLOT = CLK_HZ / (4 * REFRESH_HZ);
  localparam int CW   = $clog2(SLOT);
  localparam logic [CW-1:0] LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] GEND = CW'(GUARD_CYC - 1);

  scan_state_t   r_state, w_state_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]   r_digits;
  logic [3:0]    r_dp, r_blank;
  logic [6:0]    r_seg, w_seg_nxt;
  logic          r_dec, w_dec_nxt;
  logic [3:0]    r_an, w_an_nxt;
  logic [3:0]    w_auto, w_blank;
  logic [3:0]    w_code;
  logic [6:0]    w_glyph;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign w_auto = lz_blank(r_digits, r_dp);
`else
  assign w_auto = 4'b0000;
`endif

  assign w_blank = r_blank | w_auto;
  assign w_code  = r_digits[{w_idx_nxt, 2'b00} +: 4];

  seg7_decode u_dec (
    .i_code  (w_code),
    .o_glyph (w_glyph)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    w_seg_nxt   = SEG_OFF;
    w_dec_nxt   = 1'b1;
    w_an_nxt    = AN_OFF;
    unique case (r_state)
      GUARD: if (r_cnt == GEND) w_state_nxt = SHOW;
      SHOW: begin
        if (r_cnt == LAST) begin
          w_state_nxt = GUARD;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      default: w_state_nxt = GUARD;
    endcase
    // Outputs are registered from the state being entered.
    if (w_state_nxt == SHOW) begin
      w_an_nxt = ~(4'b0001 << w_idx_nxt);
      if (!w_blank[w_idx_nxt]) begin
        w_seg_nxt = w_glyph;
        w_dec_nxt = ~r_dp[w_idx_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= GUARD;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_dp     <= '0;
      r_blank  <= '0;
      r_seg    <= SEG_OFF;
      r_dec    <= 1'b1;
      r_an     <= AN_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_seg   <= w_seg_nxt;
      r_dec   <= w_dec_nxt;
      r_an    <= w_an_nxt;
      if (bus.load) begin
        r_digits <= bus.digits;
        r_dp     <= bus.dp_mask;
        r_blank  <= bus.blank_mask;
      end
    end
  end

  assign bus.Seg     = {1'b1, r_seg};
  assign bus.decimal = r_dec;
  assign bus.an      = r_an;

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Four-digit, time-multiplexed seven-segment driver for the stopwatch datapath. It takes four 4-bit digit codes plus decimal-point and blanking masks, captures them into a shadow register on a `load` strobe, and scans one digit at a time onto the board's common-anode display. Between digits it inserts a short anti-ghosting guard interval. It sits directly downstream of the stopwatch time counter and drives the top-level `Seg`, `decimal` and `an` pins.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `REFRESH_HZ`, 250: full-frame refresh rate, covering all 4 digits.
- `GUARD_CYC`, 64: all-anodes-off cycles at the start of each digit slot. Must be less than SLOT.
- Derived: SLOT = CLK_HZ / (4*REFRESH_HZ), which is 100_000 by default.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `load` in 1: single-cycle strobe that captures `digits`, `dp_mask` and `blank_mask` into the shadow register.
- `digits` in 16: four 4-bit codes. [3:0] is digit 0 (rightmost); [15:12] is digit 3.
- `dp_mask` in 4: bit i=1 lights the decimal point on digit i.
- `blank_mask` in 4: bit i=1 forces digit i dark, including its decimal point.
- `Seg` out 8: active-low segments. [6:0]=gfedcba; [7] is held at 1.
- `decimal` out 1: active-low decimal point.
- `an` out 4: active-low anodes. an[i] enables digit i.

## Operation
- Shadow register:
  - Written only on the `load` edge. Otherwise it holds, so a counter update never tears a frame.
  - Reset value is all zero.
- Decoder maps codes 0–15 to hex glyphs 0–9, A, b, C, d, E, F. Code 0 is 7'b1000000.
- State machine, with a 2-bit scan index `idx`:
  - GUARD: `an`=4'b1111. Lasts GUARD_CYC cycles, then goes to SHOW.
  - SHOW: `an`=~(1<<idx). Lasts SLOT−GUARD_CYC cycles, then idx increments and the block goes to GUARD.
  - idx wraps from 3 to 0.
- Slot counter:
  - Width is $clog2(SLOT).
  - Counts 0..SLOT−1 and wraps to 0.
  - GUARD occupies counts 0..GUARD_CYC−1.
- In SHOW:
  - Seg[6:0] = glyph(shadow digit idx).
  - `decimal` = ~dp_mask[idx].
  - If blank_mask[idx] is set, Seg[6:0]=7'h7F and `decimal`=1, while `an` still asserts as normal.
- In GUARD: Seg=8'hFF and `decimal`=1.
- All outputs are registered.

## Timing
- Reset values, while `reset` is low and on its release:
  - Seg=8'hFF, `decimal`=1, `an`=4'b1111.
  - State GUARD, idx=0, counter 0, shadow all zero.
- The first SHOW of digit 0 starts GUARD_CYC cycles after reset deasserts.
- Load latency:
  - `load` sampled high at edge t updates the shadow at edge t.
  - Outputs reflect the new value at edge t+1, if in SHOW.
- If `load` coincides with a GUARD/SHOW transition or an idx wrap, the new shadow applies to the digit being entered. No frame skip and no idx disturbance.
- Back-to-back `load` is legal; the last value wins.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously) and the scan restarts at digit 0.
- Frame period is exactly 4*SLOT cycles. Anode duty per digit is (SLOT−GUARD_CYC)/(4*SLOT).

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined:
  - Digits 3, 2, 1 are blanked while they and every higher digit hold code 0.
  - Digit 0 is never auto-blanked.
  - A set dp_mask bit on a digit stops blanking of that digit and all digits below it.
  - Evaluated from the shadow register.
- Undefined: all digits are shown as coded and only `blank_mask` blanks.

## Structure
- Package `seg_pkg`:
  - Glyph constant array GLYPH[16] (7-bit, active-low).
  - State enum `scan_state_t` {GUARD, SHOW}.
  - Constants SEG_OFF=7'h7F and AN_OFF=4'hF.
- Sub-module `seg7_decode`: combinational 4-bit code to 7-bit glyph, instantiated once on the shadow digit selected by idx.

## Test plan
All scenarios use CLK_HZ=400, REFRESH_HZ=10, GUARD_CYC=2, giving SLOT=10.

- Reset release:
  - Outputs are Seg=8'hFF and an=4'hF for 2 cycles.
  - Then an=4'b1110 with Seg[6:0]=7'h40 for 8 cycles.
  - Then an=4'hF for 2 cycles, then an=4'b1101.
- Load `digits`=16'h1234 and dp_mask=4'b0100:
  - Digit 0 shows glyph 4 (7'h19).
  - Digit 2 shows glyph 2 (7'h24) with `decimal`=0.
  - The full cycle is 40 cycles.
- `load` asserted on the last SHOW cycle of digit 1: digit 2's slot shows the new value, and idx order is intact.
- blank_mask=4'b1000: during digit 3's slot an=4'b0111, Seg=8'hFF and `decimal`=1.
- With `SEG_LEADING_ZERO_BLANK_EN`, digits=16'h0050: digits 3 and 2 are dark, digits 1 and 0 show 5 and 0. Without the macro, glyph 0 appears on digits 3 and 2.
- Drive `reset` low during digit 2 SHOW: outputs are at reset values in the same cycle, and after release digit 0 is shown first.
